// File: rtl/store_unit_pkg.sv
// Shared encodings and payload types for the load/store datapath.
// Holds store-select and load-select codes and the queued store entry layout.
package store_unit_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned WBE_W = 4;
    localparam int unsigned WA_W  = XLEN - 2;

    typedef enum logic [1:0] {
        ST_SB  = 2'b00,
        ST_SH  = 2'b01,
        ST_SW  = 2'b10,
        ST_NOP = 2'b11
    } st_sel_e;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } ld_sel_e;

    // One formatted store waiting for the memory write port.
    typedef struct packed {
        logic [WA_W-1:0]  waddr;
        logic [XLEN-1:0]  wdata;
        logic [WBE_W-1:0] wbe;
    } st_entry_t;

    function automatic logic [XLEN-1:0] word_to_byte_addr(input logic [WA_W-1:0] waddr);
        return {waddr, 2'b00};
    endfunction

endpackage

// File: rtl/st_format.sv
// Store data formatter: replicates rs2 into byte lanes and builds the byte-write-enable.
// Purely combinational so it can be shared with other store paths.
module st_format
    import store_unit_pkg::*;
(
    input  logic [1:0]       st_sel,
    input  logic [1:0]       byte_off,
    input  logic [XLEN-1:0]  rs2_data,
    output logic [XLEN-1:0]  wdata,
    output logic [WBE_W-1:0] wbe
);

    always_comb begin
        wdata = '0;
        wbe   = '0;
        case (st_sel_e'(st_sel))
            ST_SB: begin
                wdata = {4{rs2_data[7:0]}};
                wbe   = WBE_W'(4'b0001 << byte_off);
            end
            // Halfword is aligned down, matching the load path.
            ST_SH: begin
                wdata = {2{rs2_data[15:0]}};
                wbe   = byte_off[1] ? 4'b1100 : 4'b0011;
            end
            ST_SW: begin
                wdata = rs2_data;
                wbe   = 4'b1111;
            end
            default: begin
                wdata = '0;
                wbe   = '0;
            end
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: formats execute-stage stores, queues them in a small FIFO and
// drains them in order to the data-memory write port; flags loads hitting a pending store.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [1:0]       st_sel,
    input  logic [XLEN-1:0]  address,
    input  logic [XLEN-1:0]  rs2_data,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    output logic [WBE_W-1:0] mem_wbe,
    input  logic [XLEN-1:0]  lookup_addr,
    output logic             lookup_hit,
    output logic             empty,
    output logic [XLEN-1:0]  retired
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    st_entry_t          fifo [DEPTH];
    st_entry_t          new_entry;
    st_entry_t          head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               accept;
    logic               enq;
    logic               deq;
    logic [XLEN-1:0]    fmt_wdata;
    logic [WBE_W-1:0]   fmt_wbe;
    logic [1:0]         unused_lookup_off;

    assign unused_lookup_off = lookup_addr[1:0];

    st_format u_fmt (
        .st_sel   (st_sel),
        .byte_off (address[1:0]),
        .rs2_data (rs2_data),
        .wdata    (fmt_wdata),
        .wbe      (fmt_wbe)
    );

    // Ready depends only on local occupancy; no memory-to-execute combinational path.
    assign st_ready      = !rst && (count < CNT_W'(DEPTH));
    assign accept        = st_valid && st_ready;
    assign enq           = accept && (st_sel_e'(st_sel) != ST_NOP);
    assign mem_req_valid = (count != '0);
    assign deq           = mem_req_valid && mem_req_ready;
    assign empty         = (count == '0);

    assign new_entry.waddr = address[XLEN-1:2];
    assign new_entry.wdata = fmt_wdata;
    assign new_entry.wbe   = fmt_wbe;

    assign head      = fifo[rd_ptr];
    assign mem_addr  = word_to_byte_addr(head.waddr);
    assign mem_wdata = head.wdata;
    assign mem_wbe   = mem_req_valid ? head.wbe : '0;

    // Pointers, occupancy and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            retired <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                retired <= retired + XLEN'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted as valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo[wr_ptr] <= new_entry;
        end
    end

    // Word-granular hazard match against every live entry.
    always_comb begin
        logic [PTR_W-1:0] offs;
        lookup_hit = 1'b0;
        offs       = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offs = PTR_W'(i) - rd_ptr;
            if ((CNT_W'(offs) < count) && (fifo[i].waddr == lookup_addr[XLEN-1:2])) begin
                lookup_hit = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_store_unit;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_sel;
    logic [31:0] address;
    logic [31:0] rs2_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wbe;
    logic [31:0] lookup_addr;
    logic        lookup_hit;
    logic        empty;
    logic [31:0] retired;

    always #5 clk = ~clk;

    store_unit #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .st_valid      (st_valid),
        .st_ready      (st_ready),
        .st_sel        (st_sel),
        .address       (address),
        .rs2_data      (rs2_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wbe       (mem_wbe),
        .lookup_addr   (lookup_addr),
        .lookup_hit    (lookup_hit),
        .empty         (empty),
        .retired       (retired)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wbe;
    } ref_ent_t;

    ref_ent_t    model_q[$];
    logic [31:0] model_retired;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference formatting from lane arithmetic.
    function automatic ref_ent_t ref_format(input logic [1:0] sel, input logic [31:0] a,
                                            input logic [31:0] d);
        ref_ent_t e;
        int unsigned lane;
        lane    = a % 4;
        e.addr  = (a / 4) * 4;
        e.wdata = d;
        e.wbe   = 4'hF;
        if (sel == 2'd0) begin
            e.wdata = (d % 256) * 32'h01010101;
            e.wbe   = 4'(1 << lane);
        end else if (sel == 2'd1) begin
            e.wdata = (d % 65536) * 32'h00010001;
            e.wbe   = 4'(3 << ((lane / 2) * 2));
        end
        return e;
    endfunction

    // One cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic step(input logic r, input logic v, input logic [1:0] sel, input logic [31:0] a,
                        input logic [31:0] d, input logic mr, input logic [31:0] lk);
        logic hit;
        logic acc;
        logic deq;
        @(negedge clk);
        rst = r; st_valid = v; st_sel = sel; address = a; rs2_data = d;
        mem_req_ready = mr; lookup_addr = lk;
        #1;
        hit = 1'b0;
        foreach (model_q[i]) if ((model_q[i].addr / 4) == (lk / 4)) hit = 1'b1;
        check("st_ready", 32'(st_ready), 32'(!r && (model_q.size() < DEPTH)));
        check("mem_req_valid", 32'(mem_req_valid), 32'(model_q.size() != 0));
        check("empty", 32'(empty), 32'(model_q.size() == 0));
        check("mem_wbe", 32'(mem_wbe), (model_q.size() != 0) ? 32'(model_q[0].wbe) : 32'd0);
        if (model_q.size() != 0) begin
            check("mem_addr", mem_addr, model_q[0].addr);
            check("mem_wdata", mem_wdata, model_q[0].wdata);
        end
        check("lookup_hit", 32'(lookup_hit), 32'(hit));
        check("retired", retired, model_retired);
        if (r) begin
            model_q.delete();
            model_retired = 32'd0;
        end else begin
            acc = v && (model_q.size() < DEPTH);
            deq = (model_q.size() != 0) && mr;
            if (deq) begin
                void'(model_q.pop_front());
                model_retired = model_retired + 32'd1;
            end
            if (acc && sel != 2'd3) model_q.push_back(ref_format(sel, a, d));
        end
    endtask

    task automatic idle(input logic mr, input logic [31:0] lk);
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, mr, lk);
    endtask

    initial begin
        model_retired = 32'd0;
        rst = 1'b1; st_valid = 1'b0; st_sel = 2'd0; address = '0; rs2_data = '0;
        mem_req_ready = 1'b0; lookup_addr = '0;
        repeat (2) @(posedge clk);

        // Reset state and reset-cycle st_ready.
        step(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        idle(1'b0, 32'd0);
        check("rst_ready", 32'(st_ready), 32'd1);

        // SB then memory handshake.
        step(1'b0, 1'b1, 2'd0, 32'h1003, 32'hAABBCCDD, 1'b0, 32'd0);
        idle(1'b1, 32'd0);
        check("sb_addr", mem_addr, 32'h1000);
        check("sb_wdata", mem_wdata, 32'hDDDDDDDD);
        check("sb_wbe", 32'(mem_wbe), 32'h8);
        idle(1'b0, 32'd0);
        check("sb_retired", retired, 32'd1);

        // SH lanes and SW alignment.
        step(1'b0, 1'b1, 2'd1, 32'h2001, 32'h1234ABCD, 1'b1, 32'd0);
        step(1'b0, 1'b1, 2'd1, 32'h2002, 32'h1234ABCD, 1'b1, 32'd0);
        check("sh_lo_wdata", mem_wdata, 32'hABCDABCD);
        check("sh_lo_wbe", 32'(mem_wbe), 32'h3);
        step(1'b0, 1'b1, 2'd2, 32'h2003, 32'h55AA55AA, 1'b1, 32'd0);
        check("sh_hi_wbe", 32'(mem_wbe), 32'hC);
        idle(1'b1, 32'd0);
        check("sw_addr", mem_addr, 32'h2000);
        check("sw_wbe", 32'(mem_wbe), 32'hF);
        idle(1'b1, 32'd0);

        // Backpressure: two SWs fill, third stalls until drain.
        step(1'b0, 1'b1, 2'd2, 32'h5000, 32'h11111111, 1'b0, 32'd0);
        step(1'b0, 1'b1, 2'd2, 32'h5004, 32'h22222222, 1'b0, 32'd0);
        step(1'b0, 1'b1, 2'd2, 32'h5008, 32'h33333333, 1'b0, 32'd0);
        check("bp_full_ready", 32'(st_ready), 32'd0);
        step(1'b0, 1'b1, 2'd2, 32'h5008, 32'h33333333, 1'b1, 32'd0);
        step(1'b0, 1'b1, 2'd2, 32'h5008, 32'h33333333, 1'b1, 32'd0);
        check("bp_ready_back", 32'(st_ready), 32'd1);
        repeat (3) idle(1'b1, 32'd0);

        // Streaming, one store per cycle with memory always ready.
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 2'(i % 3), 32'h6000 + 32'(i), $urandom, 1'b1, 32'h6000);
        repeat (2) idle(1'b1, 32'd0);

        // Lookup hazard matching.
        step(1'b0, 1'b1, 2'd0, 32'h3001, 32'h000000EE, 1'b0, 32'd0);
        idle(1'b0, 32'h3002);
        check("lk_hit", 32'(lookup_hit), 32'd1);
        idle(1'b0, 32'h3004);
        check("lk_miss", 32'(lookup_hit), 32'd0);
        idle(1'b1, 32'h3002);
        idle(1'b1, 32'h3002);
        check("lk_drained", 32'(lookup_hit), 32'd0);

        // Reset while full and stalled, then NOP and a lone SW.
        step(1'b0, 1'b1, 2'd2, 32'h7000, 32'hCAFEF00D, 1'b0, 32'd0);
        step(1'b0, 1'b1, 2'd2, 32'h7004, 32'hBEEFBEEF, 1'b0, 32'd0);
        step(1'b1, 1'b1, 2'd2, 32'h7008, 32'h0BADCAFE, 1'b0, 32'h7000);
        check("mid_rst_ready", 32'(st_ready), 32'd0);
        step(1'b0, 1'b1, 2'd3, 32'h7100, 32'h12345678, 1'b0, 32'h7000);
        check("post_rst_empty", 32'(empty), 32'd1);
        check("post_rst_retired", retired, 32'd0);
        step(1'b0, 1'b1, 2'd2, 32'h7200, 32'h87654321, 1'b0, 32'd0);
        check("nop_empty", 32'(empty), 32'd1);
        idle(1'b1, 32'd0);
        check("lone_sw", mem_wdata, 32'h87654321);
        idle(1'b0, 32'd0);

        // Randomized traffic in a small address window so lookups hit.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 32'h4000 + 32'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 2) != 0), 32'h4000 + 32'($urandom_range(0, 31)));
        end
        repeat (4) idle(1'b1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_unit.md
# store_unit

Store-side counterpart of the load extractor in the writeback path. Accepts store requests (SB/SH/SW) from the execute stage. Formats rs2 data into the addressed byte lanes with a 4-bit byte-write-enable, then queues the formatted write in a small FIFO. Drains the FIFO to the data-memory write port over a valid/ready handshake, and flags loads that hit a pending store so hazard logic can stall them.

## Interface
- `DEPTH`, default 2: FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `st_valid`  in  1  store request present.
- `st_ready`  out  1  store unit can accept this cycle.
- `st_sel`  in  2  00 SB, 01 SH, 10 SW, 11 no-op.
- `address`  in  32  byte address of the store.
- `rs2_data`  in  32  store source register value.
- `mem_req_valid`  out  1  head entry presented to memory.
- `mem_req_ready`  in  1  memory accepts head entry.
- `mem_addr`  out  32  word address of head entry, {addr[31:2],2'b00}.
- `mem_wdata`  out  32  lane-replicated write data of head entry.
- `mem_wbe`  out  4  byte-write-enable of head entry; 0000 when empty.
- `lookup_addr`  in  32  address of a load in flight.
- `lookup_hit`  out  1  a valid entry has the same word address as the load.
- `empty`  out  1  no entries pending (fence/drain indicator).
- `retired`  out  32  wrapping count of stores accepted by memory.

## Operation
- Formatting, by `st_sel`:
  - SB: wdata = {4{rs2[7:0]}}, wbe = 4'b0001 << address[1:0].
  - SH: wdata = {2{rs2[15:0]}}, wbe = address[1] ? 1100 : 0011; address[0] is ignored (halfword aligned down, matching the load path).
  - SW: wdata = rs2, wbe = 1111; address[1:0] is ignored.
- Enqueue on st_valid && st_ready, except st_sel=11: that request is handshaken but nothing is enqueued.
- `st_ready` = !rst && (count < DEPTH). It does not depend on `mem_req_ready`, so no combinational path runs memory → execute.
- Dequeue on mem_req_valid && mem_req_ready; `retired` increments by 1, wrapping 2^32−1 → 0.
- `mem_req_valid` = (count != 0). Head fields come straight from storage. When empty, `mem_wbe` = 0000; `mem_addr` and `mem_wdata` are don't-care.
- Pointers `wr_ptr`/`rd_ptr` are log2(DEPTH) bits and wrap modulo DEPTH. `count` is log2(DEPTH)+1 bits.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. This can only happen when 1 ≤ count ≤ DEPTH−1, because a full FIFO deasserts `st_ready`.
- Dequeue only when empty: impossible, since valid is low.
- `lookup_hit` (combinational): OR over valid entries of (entry.addr[31:2] == lookup_addr[31:2]). Byte-lane overlap is not checked; the match is word-granular and conservative.
- `empty` = (count == 0).
- FIFO order is strict; writes never reorder or merge.

## Timing
- Store accepted in cycle N → visible on the memory port (`mem_req_valid`=1) in cycle N+1 at the earliest.
- Head held stable while `mem_req_valid` && !`mem_req_ready`.
- Throughput: 1 store/cycle sustained when memory is always ready.
- Reset (synchronous, any cycle, including mid-drain or when full):
  - count, pointers and `retired` go to 0; `mem_req_valid` = 0, `mem_wbe` = 0000, `empty` = 1, `lookup_hit` = 0.
  - Pending entries are discarded.
  - `st_ready` = 0 during the reset cycle and 1 in the first cycle after.
- `lookup_hit` reflects state at the start of the cycle; an entry enqueued in the same cycle is not yet visible.

## Structure
- Shared package/header holds the ST_SB/ST_SH/ST_SW/ST_NOP encodings alongside the load-select encodings.
- Sub-module `st_format`: purely combinational (st_sel, address[1:0], rs2_data) → (wdata, wbe). It is reused by any future uncached store path.
- Top level holds the FIFO, pointers, count, `retired` counter and lookup comparators.

## Test plan
- SB with address=0x1003, rs2=0xAABBCCDD → mem_addr=0x1000, wdata=0xDDDDDDDD, wbe=1000 one cycle later; `retired`=1 after the memory handshake.
- SH with address=0x2001, rs2=0x1234ABCD → wdata=0xABCDABCD, wbe=0011. SH with address=0x2002 → wbe=1100. SW with address=0x2003 → mem_addr=0x2000, wbe=1111.
- Backpressure, DEPTH=2, mem_req_ready=0:
  - Two SWs accepted, then `st_ready`=0 and a third request stalls.
  - Raise ready: stores drain in order, `st_ready` returns 1 after the first dequeue, and the third store completes.
- Streaming: mem_req_ready=1, one store per cycle for 8 cycles → count stays ≤1, output order matches input, `retired`=8.
- Lookup:
  - Pending SB at 0x3001, lookup 0x3002 → hit=1.
  - Lookup 0x3004 → hit=0.
  - After the entry drains, lookup 0x3002 → hit=0.
- Reset mid-operation with FIFO full and mem stalled → next cycle `empty`=1, `mem_wbe`=0000, `retired`=0; the first post-reset SW appears alone on the port. Also a st_sel=11 request is handshaken and enqueues nothing.
